uart_tx_scheduler: RTL

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler_if.sv | 29 ++
 rtl/uart_tx_scheduler.sv | 106 ++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Requester/serializer bundle for the UART transmit scheduler.
// The scheduler attaches as slave; requesters and the serializer model attach as master.
interface uart_tx_scheduler_if;
    logic [2:0]  i_req;
    logic [2:0]  i_mode;
    logic [95:0] i_words;
    logic [23:0] i_bytes;
    logic        i_tx_done;
    logic [2:0]  o_ack;
    logic [2:0]  o_err;
    logic [1:0]  o_grant;
    logic        o_busy;
    logic        o_tx_enable;
    logic        o_tx_mode;
    logic [31:0] o_tx_word;
    logic [7:0]  o_tx_byte;

    modport master (
        output i_req, i_mode, i_words, i_bytes, i_tx_done,
        input  o_ack, o_err, o_grant, o_busy, o_tx_enable,
        input  o_tx_mode, o_tx_word, o_tx_byte
    );

    modport slave (
        input  i_req, i_mode, i_words, i_bytes, i_tx_done,
        output o_ack, o_err, o_grant, o_busy, o_tx_enable,
        output o_tx_mode, o_tx_word, o_tx_byte
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that hands one of three requesters' byte/word payloads
// to a serializer, waits for done (or a timeout) and reports ack/err.
module uart_tx_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic              clock,
    input  logic              reset,
    uart_tx_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [1:0]  last;
    logic [31:0] wait_count;
    logic [5:0]  order;
    logic [1:0]  winner;
    logic        winner_valid;

    // Priority order starts just after the last served requester; scanning from
    // lowest to highest priority lets the highest-priority match win.
    always_comb begin
        order = {2'd2, 2'd1, 2'd0};
        case (last)
            2'd0:    order = {2'd0, 2'd2, 2'd1};
            2'd1:    order = {2'd1, 2'd0, 2'd2};
            default: order = {2'd2, 2'd1, 2'd0};
        endcase
        winner       = order[1:0];
        winner_valid = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (bus.i_req[order[2*k +: 2]]) begin
                winner       = order[2*k +: 2];
                winner_valid = 1'b1;
            end
        end
    end

    // Payload is captured at grant time so later i_req/i_words changes cannot
    // disturb the transfer in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            last            <= 2'd2;
            wait_count      <= 32'd0;
            bus.o_ack       <= 3'b000;
            bus.o_err       <= 3'b000;
            bus.o_grant     <= 2'd0;
            bus.o_busy      <= 1'b0;
            bus.o_tx_enable <= 1'b0;
            bus.o_tx_mode   <= 1'b0;
            bus.o_tx_word   <= 32'd0;
            bus.o_tx_byte   <= 8'd0;
        end else begin
            bus.o_ack       <= 3'b000;
            bus.o_err       <= 3'b000;
            bus.o_tx_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (winner_valid) begin
                        bus.o_grant     <= winner;
                        bus.o_tx_mode   <= bus.i_mode[winner];
                        bus.o_tx_word   <= bus.i_words[32*winner +: 32];
                        bus.o_tx_byte   <= bus.i_bytes[8*winner +: 8];
                        bus.o_tx_enable <= 1'b1;
                        bus.o_busy      <= 1'b1;
                        state           <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wait_count <= 32'd0;
                    state      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.i_tx_done) begin
                        bus.o_ack <= 3'b001 << bus.o_grant;
                        last      <= bus.o_grant;
                        state     <= RELEASE;
                    end else if (wait_count == TIMEOUT_LAST) begin
                        bus.o_err  <= 3'b001 << bus.o_grant;
                        last       <= bus.o_grant;
                        bus.o_busy <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        wait_count <= wait_count + 32'd1;
                    end
                end
                RELEASE: begin
                    if (!bus.i_tx_done) begin
                        bus.o_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
